note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Step sequencer that drives the synth voice: it configures the frequency divider (note switch code, octave) and gates the waveform enable on a programmable tempo.
- Holds a small pattern RAM of note steps written by a host/config interface.
- Plays steps 0..last_step in a loop while run is high.
- Sits between the board controls/config logic and the clk_div / LUT generator enables in the synth wrapper.

Parameters:
- STEPS, 8, number of pattern entries (power of 2); AW = log2(STEPS) = 3
- TEMPO_W, 24, width of step_len/gate_len cycle counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; sequencer plays while high (pre-debounced)
- wr_en  in  1  write strobe for pattern RAM
- wr_addr  in  AW  pattern entry to write
- wr_data  in  14  {rest, octave[1:0], sw[11:1]}
- last_step  in  AW  index of final step in loop
- step_len  in  TEMPO_W  clk cycles per step (0 treated as 1)
- gate_len  in  TEMPO_W  clk cycles en_out is high within a step
- sw_out  out  11  note code to clk_div sw[11:1]
- octave_out  out  2  octave to clk_div
- en_out  out  1  waveform enable (gate)
- step_idx  out  AW  currently playing step
- step_pulse  out  1  one-cycle strobe at each step start

Behaviour:
- Reset:
  - all outputs 0 and state IDLE
  - step counter and cycle counter 0
  - every pattern entry set to 14'h2000 (rest=1, octave 0, sw 0)
  - applies mid-operation: output drops next cycle, no partial step completes
- Writes: wr_en writes wr_data to entry wr_addr at posedge in any state.
  - Read-before-write: a write in the same cycle as a step load is not seen by that load.
  - Playing outputs are latched at step start, so a write to the current step takes effect on its next visit.
- FSM states: IDLE, GATE, HOLD.
- IDLE:
  - en_out=0, step_idx=0, cycle counter=0
  - run=1 -> load entry 0, step_pulse=1, go to GATE (rest) or GATE with en_out=1.
  - Latency from run rising edge to step_pulse/en_out: 1 clk.
- Step load (one cycle, at step start):
  - latch sw_out/octave_out from the entry
  - en_out = ~rest & (gate_len != 0)
  - cycle counter = 1
  - step_pulse=1
- GATE:
  - counter increments each cycle
  - when counter == gate_len and gate_len < step_len: en_out -> 0, go to HOLD
- HOLD: en_out=0, counter increments.
- Step boundary: when counter == max(step_len,1), the next cycle loads the next step.
  - step_idx wraps to 0 when step_idx >= last_step; this also covers last_step being lowered mid-run.
- gate_len >= step_len:
  - en_out stays high the whole step
  - across the boundary into a non-rest step en_out stays continuously high (legato)
  - into a rest step en_out drops in the load cycle
- Rest step: en_out=0 for the whole step; sw_out/octave_out hold the previous values (no divider glitch).
- run deassert in any state: next cycle IDLE, en_out=0, step_idx=0; sw_out/octave_out hold.
- run re-assert always restarts at step 0.
- step_len changed mid-step: new value is used by the boundary compare immediately. If the counter already exceeds the new value, the boundary fires next cycle (use >= compare).
- Counter saturates; never wraps.

Decomposition:
- Shared package synth_pkg:
  - step entry field positions (REST_BIT=13, OCT_MSB=12, OCT_LSB=11, SW_MSB=10)
  - REST_ENTRY = 14'h2000
  - state encoding (IDLE=2'd0, GATE=2'd1, HOLD=2'd2)
- One natural sub-module: seq_pattern_ram (STEPS x 14 register array, sync write, async read, sync reset to REST_ENTRY).

Test Plan:
1. Reset with run=1 -> all outputs 0; after rst release, step_pulse on the next cycle and step_idx=0; read-back via playback shows all steps rest (en_out never high).
2. Write steps 0..2 = {0,2'd1,11'h001},{0,2'd2,11'h010},{0,2'd0,11'h400}; last_step=2, step_len=10, gate_len=6, run=1:
   - step_pulse every 10 clks
   - en_out high 6 clks / low 4 clks per step
   - sw_out sequence 001,010,400,001
   - octave_out 1,2,0,1
3. Same pattern with gate_len=10 -> en_out continuously high across all boundaries; sw_out still changes every 10 clks.
4. Set step 1 rest=1 -> en_out low for all 10 clks of step 1; sw_out/octave_out hold 001/1 during step 1.
5. Drop run at cycle 4 of step 1 -> en_out=0 and step_idx=0 next cycle. Re-raise run -> step_pulse 1 clk later with sw_out=001.
6. While on step 2 with last_step=3, write last_step=1 and write entry 2 -> boundary wraps to step 0. Step 2 new data plays on the next visit after last_step is restored to 3.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice control path: pattern entry layout
// and the step sequencer state encoding.
package synth_pkg;

    localparam int ENTRY_W  = 14;
    localparam int REST_BIT = 13;
    localparam int OCT_MSB  = 12;
    localparam int OCT_LSB  = 11;
    localparam int SW_MSB   = 10;
    localparam int SW_W     = SW_MSB + 1;

    localparam logic [ENTRY_W-1:0] REST_ENTRY = 14'h2000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } seq_state_e;

    // Field order matches {rest, octave[1:0], sw[11:1]} on the config bus.
    typedef struct packed {
        logic                rest;
        logic [1:0]          octave;
        logic [SW_W-1:0]     sw;
    } step_entry_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern storage for the step sequencer: STEPS x 14-bit entries, written
// synchronously by the host and read combinationally by the step loader.
module seq_pattern_ram
    import synth_pkg::*;
#(
    parameter int STEPS = 8,
    parameter int AW    = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [STEPS];

    // NOTE: the array is reset entry by entry so a freshly reset pattern plays
    // as silence; this keeps it in flops rather than a RAM macro, which is
    // fine at this depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                mem[i] <= REST_ENTRY;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Async read: a load in the same cycle as a write sees the old entry.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer driving the synth voice: loops through pattern entries at a
// programmable tempo, latching note/octave per step and gating the waveform.
module note_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS   = 8,
    parameter int TEMPO_W = 24,
    parameter int AW      = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      last_step,
    input  logic [TEMPO_W-1:0] step_len,
    input  logic [TEMPO_W-1:0] gate_len,
    output logic [SW_W-1:0]    sw_out,
    output logic [1:0]         octave_out,
    output logic               en_out,
    output logic [AW-1:0]      step_idx,
    output logic               step_pulse
);

    seq_state_e         state, state_nxt;
    logic [TEMPO_W-1:0] cnt, cnt_nxt;
    logic [TEMPO_W-1:0] step_eff;
    logic [AW-1:0]      rd_addr, wrap_idx;
    logic [ENTRY_W-1:0] rd_data;
    step_entry_t        entry;
    logic               load;

    logic [SW_W-1:0]    sw_nxt;
    logic [1:0]         oct_nxt;
    logic               en_nxt, pulse_nxt;
    logic [AW-1:0]      idx_nxt;

    seq_pattern_ram #(
        .STEPS (STEPS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign entry    = step_entry_t'(rd_data);
    assign step_eff = (step_len == '0) ? TEMPO_W'(1) : step_len;
    // Wrap on >= so lowering last_step below the current step still wraps.
    assign wrap_idx = (step_idx >= last_step) ? '0 : step_idx + AW'(1);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sw_nxt    = sw_out;
        oct_nxt   = octave_out;
        en_nxt    = en_out;
        idx_nxt   = step_idx;
        pulse_nxt = 1'b0;
        load      = 1'b0;
        rd_addr   = '0;

        if (!run) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            en_nxt    = 1'b0;
            idx_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    load    = 1'b1;
                    rd_addr = '0;
                end
                GATE, HOLD: begin
                    if (cnt >= step_eff) begin
                        load    = 1'b1;
                        rd_addr = wrap_idx;
                    end else begin
                        cnt_nxt = (cnt == '1) ? cnt : cnt + TEMPO_W'(1);
                        if (state == GATE && cnt == gate_len && gate_len < step_eff) begin
                            en_nxt    = 1'b0;
                            state_nxt = HOLD;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Outputs are latched only here, so a rest step keeps the divider on
        // its previous note and legato steps never drop the gate.
        if (load) begin
            state_nxt = GATE;
            idx_nxt   = rd_addr;
            cnt_nxt   = TEMPO_W'(1);
            pulse_nxt = 1'b1;
            en_nxt    = !entry.rest && (gate_len != '0);
            if (!entry.rest) begin
                sw_nxt  = entry.sw;
                oct_nxt = entry.octave;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sw_out     <= '0;
            octave_out <= '0;
            en_out     <= 1'b0;
            step_idx   <= '0;
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            sw_out     <= sw_nxt;
            octave_out <= oct_nxt;
            en_out     <= en_nxt;
            step_idx   <= idx_nxt;
            step_pulse <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed scenarios plus random
// traffic, compared every cycle against a step/position-based reference model.
module tb_note_sequencer;

    localparam int STEPS   = 8;
    localparam int TEMPO_W = 24;
    localparam int AW      = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [13:0]        wr_data;
    logic [AW-1:0]      last_step;
    logic [TEMPO_W-1:0] step_len;
    logic [TEMPO_W-1:0] gate_len;
    logic [10:0]        sw_out;
    logic [1:0]         octave_out;
    logic               en_out;
    logic [AW-1:0]      step_idx;
    logic               step_pulse;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: which entry is playing and how many cycles into it.
    logic [13:0]   m_ram [STEPS];
    bit            m_play;
    logic [AW-1:0] m_idx;
    int            m_pos;
    bit            m_rest;
    logic [10:0]   m_sw;
    logic [1:0]    m_oct;
    logic          m_en;
    logic          m_pulse;

    note_sequencer #(
        .STEPS   (STEPS),
        .TEMPO_W (TEMPO_W),
        .AW      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .last_step  (last_step),
        .step_len   (step_len),
        .gate_len   (gate_len),
        .sw_out     (sw_out),
        .octave_out (octave_out),
        .en_out     (en_out),
        .step_idx   (step_idx),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int            eff;
        logic [AW-1:0] nidx;
        logic [13:0]   e;
        eff = (step_len == 0) ? 1 : int'(step_len);
        if (rst) begin
            m_play = 0; m_idx = '0; m_pos = 0; m_rest = 0;
            m_sw = '0; m_oct = '0; m_en = 1'b0; m_pulse = 1'b0;
            for (int i = 0; i < STEPS; i++) m_ram[i] = 14'h2000;
            return;
        end
        if (!run) begin
            m_play = 0; m_idx = '0; m_pos = 0; m_en = 1'b0; m_pulse = 1'b0;
        end else if (!m_play || m_pos >= eff) begin
            nidx    = !m_play ? '0 : ((m_idx >= last_step) ? '0 : m_idx + 3'd1);
            e       = m_ram[nidx];
            m_play  = 1;
            m_idx   = nidx;
            m_pos   = 1;
            m_pulse = 1'b1;
            m_rest  = e[13];
            if (!m_rest) begin
                m_sw  = e[10:0];
                m_oct = e[12:11];
            end
            m_en = !m_rest && gate_len != 0;
        end else begin
            m_pulse = 1'b0;
            m_pos++;
            m_en = !m_rest && gate_len != 0 && (m_pos <= int'(gate_len) || int'(gate_len) >= eff);
        end
        if (wr_en) m_ram[wr_addr] = wr_data;
    endtask

    task automatic tick(input string tag = "cycle");
        model_step();
        @(posedge clk);
        #1;
        check(tag, 32'({sw_out, octave_out, en_out, step_idx, step_pulse}),
                   32'({m_sw, m_oct, m_en, m_idx, m_pulse}));
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [13:0] d, input string tag);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick(tag);
        wr_en = 1'b0;
    endtask

    // Bounded wait on the model's position; an expired budget counts as a miscompare.
    task automatic wait_pos(input logic [AW-1:0] idx, input int pos, input string tag);
        int n = 0;
        while (!(m_play && m_idx == idx && m_pos == pos) && n < 200) begin
            tick(tag);
            n++;
        end
        check({tag, "_reached"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        last_step = 3'd7; step_len = 24'd4; gate_len = 24'd2;

        // Reset held with run high: everything quiet.
        ticks(3, "reset_hold");
        check("reset_outputs", 32'({sw_out, octave_out, en_out, step_idx, step_pulse}), 32'd0);
        rst = 1'b0;
        tick("reset_release");
        check("first_pulse", 32'(step_pulse), 32'd1);
        check("first_idx", 32'(step_idx), 32'd0);
        ticks(40, "all_rest_playback");

        // Three-note loop, 10-cycle steps with a 6-cycle gate.
        run = 1'b0;
        tick("stop");
        write_entry(3'd0, {1'b0, 2'd1, 11'h001}, "wr0");
        write_entry(3'd1, {1'b0, 2'd2, 11'h010}, "wr1");
        write_entry(3'd2, {1'b0, 2'd0, 11'h400}, "wr2");
        last_step = 3'd2; step_len = 24'd10; gate_len = 24'd6; run = 1'b1;
        ticks(45, "gate6");

        // Gate as long as the step: legato across boundaries.
        run = 1'b0;
        tick("stop");
        gate_len = 24'd10; run = 1'b1;
        ticks(45, "legato");

        // Step 1 becomes a rest while playing.
        write_entry(3'd1, {1'b1, 2'd2, 11'h010}, "wr_rest1");
        ticks(45, "rest_step");

        // Drop run four cycles into step 1, then restart.
        wait_pos(3'd1, 4, "seek_s1");
        run = 1'b0;
        tick("run_drop");
        check("drop_en", 32'(en_out), 32'd0);
        check("drop_idx", 32'(step_idx), 32'd0);
        run = 1'b1;
        tick("run_raise");
        check("restart_pulse", 32'(step_pulse), 32'd1);
        check("restart_sw", 32'(sw_out), 32'h001);
        check("restart_oct", 32'(octave_out), 32'd1);
        ticks(15, "restart_play");

        // Lower last_step while on step 2, rewrite entry 2, then restore.
        write_entry(3'd3, {1'b0, 2'd3, 11'h155}, "wr3");
        last_step = 3'd3;
        wait_pos(3'd2, 2, "seek_s2");
        last_step = 3'd1;
        write_entry(3'd2, {1'b0, 2'd3, 11'h2aa}, "wr2_new");
        ticks(40, "wrap_low");
        last_step = 3'd3;
        ticks(60, "wrap_restored");

        // Shorten step_len below the current count mid-step, then length 0.
        gate_len = 24'd6; run = 1'b0;
        tick("stop");
        run = 1'b1;
        wait_pos(3'd0, 5, "seek_pos5");
        step_len = 24'd3;
        ticks(20, "step_shrink");
        step_len = 24'd0;
        ticks(10, "step_len0");
        step_len = 24'd1;
        ticks(10, "step_len1");

        // Random traffic; gate_len only changes while stopped.
        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, STEPS - 1));
            wr_data = 14'($urandom);
            if ($urandom_range(0, 63) == 0) run = ~run;
            if (!run) gate_len = TEMPO_W'($urandom_range(0, 9));
            if ($urandom_range(0, 99) == 0) step_len = TEMPO_W'($urandom_range(0, 9));
            if ($urandom_range(0, 49) == 0) last_step = AW'($urandom_range(0, STEPS - 1));
            rst = ($urandom_range(0, 499) == 0);
            tick("random");
        end
        rst = 1'b0; wr_en = 1'b0;
        ticks(5, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
